// File: rtl/flash_stream_reader_if.sv
// flash_stream_reader_if: Wishbone read-master bundle between the flash stream
// reader (master) and the QSPI flash memory-mapped read port (slave).
interface flash_stream_reader_if;
  logic [31:0] m_wb_adr_o;
  logic        m_wb_cyc_o;
  logic        m_wb_stb_o;
  logic [31:0] m_wb_dat_i;
  logic        m_wb_ack_i;

  modport master (
    output m_wb_adr_o,
    output m_wb_cyc_o,
    output m_wb_stb_o,
    input  m_wb_dat_i,
    input  m_wb_ack_i
  );

  modport slave (
    input  m_wb_adr_o,
    input  m_wb_cyc_o,
    input  m_wb_stb_o,
    output m_wb_dat_i,
    output m_wb_ack_i
  );
endinterface

// File: rtl/flash_stream_reader.sv
// flash_stream_reader: issues strictly sequential 32-bit Wishbone reads from a
// word-aligned flash address and streams the returned words through a small FIFO.
// One read outstanding at a time; the bus is only requested when a FIFO slot is free.
// Optional macro FLASH_STREAM_CHECKSUM_EN adds a 32-bit running sum of pushed words.
module flash_stream_reader #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000
) (
  input  logic                  wb_clk_i,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [23:0]           cmd_addr,
  input  logic [15:0]           cmd_words,
  input  logic                  abort,
  flash_stream_reader_if.master wb,
  output logic                  out_valid,
  output logic [31:0]           out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
`ifdef FLASH_STREAM_CHECKSUM_EN
  ,
  output logic [31:0]           checksum
`endif
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t                 state_reg;
  logic                   cyc_reg;
  logic [23:0]            cur_addr_reg;
  logic [15:0]            remaining_reg;
  logic                   done_reg;

  logic [31:0]            fifo_data_reg [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]  fifo_last_reg;
  logic [PTR_W-1:0]       wr_ptr_reg;
  logic [PTR_W-1:0]       rd_ptr_reg;
  logic [CNT_W-1:0]       count_reg;

  logic abort_hit;
  logic push;
  logic pop;
  logic room;
  logic drained;

  // Abort only matters while a command is active; an ack in the abort cycle is dropped.
  assign abort_hit = abort && (state_reg != IDLE);
  assign push      = (state_reg == REQ) && cyc_reg && wb.m_wb_ack_i && !abort_hit;
  assign pop       = out_valid && out_ready;
  // A slot counts as free if the head word leaves this very cycle.
  assign room      = (count_reg != DEPTH_C) || pop;
  // Drain finishes when the FIFO is empty after this cycle's pop.
  assign drained   = (count_reg == '0) || ((count_reg == CNT_W'(1)) && pop);

  assign cmd_ready     = (state_reg == IDLE);
  assign busy          = (state_reg != IDLE);
  assign done          = done_reg;
  assign wb.m_wb_adr_o = ADDR_BASE | {8'h00, cur_addr_reg};
  assign wb.m_wb_cyc_o = cyc_reg;
  assign wb.m_wb_stb_o = cyc_reg;
  assign out_valid     = (count_reg != '0);
  assign out_data      = fifo_data_reg[rd_ptr_reg];
  assign out_last      = fifo_last_reg[rd_ptr_reg] && out_valid;

  // FIFO storage: capture each acknowledged word and whether it ends the command.
  always_ff @(posedge wb_clk_i) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_reg[i] <= '0;
      end
      fifo_last_reg <= '0;
    end else if (push) begin
      fifo_data_reg[wr_ptr_reg] <= wb.m_wb_dat_i;
      fifo_last_reg[wr_ptr_reg] <= (remaining_reg == 16'd1);
    end
  end

  // FIFO pointers and occupancy; an abort flushes everything in one cycle.
  always_ff @(posedge wb_clk_i) begin
    if (!resetn || abort_hit) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Command FSM: accept, sequential single reads with a one-cycle gap, drain, done.
  always_ff @(posedge wb_clk_i) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      cyc_reg       <= 1'b0;
      cur_addr_reg  <= '0;
      remaining_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (abort_hit) begin
        state_reg <= IDLE;
        cyc_reg   <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (cmd_valid) begin
              cur_addr_reg  <= {cmd_addr[23:2], 2'b00};
              remaining_reg <= cmd_words;
              if (cmd_words == 16'd0) begin
                done_reg <= 1'b1;
              end else begin
                // FIFO is always empty in IDLE, so the first read can start at once.
                state_reg <= REQ;
                cyc_reg   <= 1'b1;
              end
            end
          end
          REQ: begin
            if (cyc_reg) begin
              if (wb.m_wb_ack_i) begin
                cyc_reg       <= 1'b0;
                cur_addr_reg  <= cur_addr_reg + 24'd4;
                remaining_reg <= remaining_reg - 16'd1;
                if (remaining_reg == 16'd1) state_reg <= DRAIN;
              end
            end else if (room) begin
              cyc_reg <= 1'b1;
            end
          end
          DRAIN: begin
            if (drained) begin
              done_reg  <= 1'b1;
              state_reg <= IDLE;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

`ifdef FLASH_STREAM_CHECKSUM_EN
  logic [31:0] checksum_reg;

  // Running sum of every pushed word, restarted when a command is accepted.
  always_ff @(posedge wb_clk_i) begin
    if (!resetn) begin
      checksum_reg <= '0;
    end else if ((state_reg == IDLE) && cmd_valid) begin
      checksum_reg <= '0;
    end else if (push) begin
      checksum_reg <= checksum_reg + wb.m_wb_dat_i;
    end
  end

  assign checksum = checksum_reg;
`endif
endmodule

// File: tb/tb_flash_stream_reader.sv
// tb_flash_stream_reader: table-driven check of flash_stream_reader with a
// Wishbone slave whose read data equals the bus address, plus abort/checksum sequences.
module tb_flash_stream_reader;
  localparam int FIFO_DEPTH = 4;

  typedef struct {
    logic [23:0]      addr;
    logic [15:0]      words;
    int               stall;
    int               lat;
    logic [0:7][23:0] exp_adr;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [23:0] cmd_addr = '0;
  logic [15:0] cmd_words = '0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;
  logic        cmd_ready, out_valid, out_last, busy, done;
  logic [31:0] out_data;
`ifdef FLASH_STREAM_CHECKSUM_EN
  logic [31:0] checksum;
  logic [31:0] ck_done = '0;
`endif

  flash_stream_reader_if bus();

  int n_vec = 0;
  int n_bad = 0;
  int lat = 0;
  int wait_cnt = 0;
  logic [31:0] tab [4];
  bit  use_tab = 1'b0;
  int  tab_idx = 0;
  int  tab_base = 0;

  vec_t vecs [5];

  // monitor state
  logic [31:0] rd_q [$];
  logic [32:0] pop_q [$];
  int cyc_cnt = 0, done_cnt = 0, done_cyc = 0, last_pop_cyc = 0;
  int busy_cnt = 0, cyc_hi_cnt = 0, valid_cnt = 0;
  int stb_err = 0, adr_err = 0, gap_err = 0, hold_err = 0;
  logic p_cyc = 0, p_ack = 0, p_valid = 0, p_ready = 0, p_last = 0, p_abort = 0;
  logic [31:0] p_adr = '0, p_data = '0;

  flash_stream_reader #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_BASE(32'h0000_0000)) dut (
    .wb_clk_i (clk),
    .resetn   (resetn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr (cmd_addr),
    .cmd_words(cmd_words),
    .abort    (abort),
    .wb       (bus),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
`ifdef FLASH_STREAM_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  always #5 clk = ~clk;

  // Slave: ack after lat wait cycles (0 = same cycle), data = address or a table.
  assign bus.m_wb_ack_i = bus.m_wb_cyc_o && (wait_cnt >= lat);
  assign bus.m_wb_dat_i = use_tab ? tab[2'(tab_idx - tab_base)] : bus.m_wb_adr_o;

  always @(posedge clk) begin
    if (bus.m_wb_cyc_o && !bus.m_wb_ack_i) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (bus.m_wb_cyc_o && bus.m_wb_ack_i) tab_idx <= tab_idx + 1;
  end

  // Monitor sampled mid-cycle: records reads, pops, done and protocol violations.
  always @(negedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (resetn) begin
      if (bus.m_wb_stb_o !== bus.m_wb_cyc_o) stb_err <= stb_err + 1;
      if (p_cyc && !p_ack && bus.m_wb_cyc_o && (bus.m_wb_adr_o !== p_adr)) adr_err <= adr_err + 1;
      if (p_cyc && p_ack && bus.m_wb_cyc_o) gap_err <= gap_err + 1;
      if (p_valid && !p_ready && !p_abort &&
          (!out_valid || (out_data !== p_data) || (out_last !== p_last))) hold_err <= hold_err + 1;
      if (bus.m_wb_cyc_o && bus.m_wb_ack_i) rd_q.push_back(bus.m_wb_adr_o);
      if (out_valid && out_ready) begin
        pop_q.push_back({out_last, out_data});
        last_pop_cyc <= cyc_cnt;
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc_cnt;
`ifdef FLASH_STREAM_CHECKSUM_EN
        ck_done <= checksum;
`endif
      end
      if (busy) busy_cnt <= busy_cnt + 1;
      if (bus.m_wb_cyc_o) cyc_hi_cnt <= cyc_hi_cnt + 1;
      if (out_valid) valid_cnt <= valid_cnt + 1;
    end
    p_cyc   <= bus.m_wb_cyc_o;
    p_ack   <= bus.m_wb_ack_i;
    p_adr   <= bus.m_wb_adr_o;
    p_valid <= out_valid;
    p_ready <= out_ready;
    p_data  <= out_data;
    p_last  <= out_last;
    p_abort <= abort;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int db, input string tag);
    bit got;
    got = 1'b0;
    for (int t = 0; t < 1000 && !got; t++) begin
      @(negedge clk);
      if (done_cnt != db) got = 1'b1;
    end
    chk($sformatf("%s done_seen", tag), 32'(got), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int rb, pb, db, bb, cb, vb, w, n;
    rb = rd_q.size(); pb = pop_q.size(); db = done_cnt;
    bb = busy_cnt; cb = cyc_hi_cnt; vb = valid_cnt;
    w = int'(v.words);
    @(posedge clk); #1;
    lat = v.lat; out_ready = (v.stall == 0);
    cmd_addr = v.addr; cmd_words = v.words; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (v.stall > 0) begin
      repeat (v.stall) @(posedge clk);
      @(negedge clk);
      chk($sformatf("%s stall_reads", tag), 32'(rd_q.size() - rb),
          32'((w < FIFO_DEPTH) ? w : FIFO_DEPTH));
      chk($sformatf("%s stall_cyc", tag), 32'(bus.m_wb_cyc_o), 32'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
    wait_done(db, tag);
    repeat (4) @(negedge clk);
    chk($sformatf("%s reads", tag), 32'(rd_q.size() - rb), 32'(w));
    chk($sformatf("%s pops", tag), 32'(pop_q.size() - pb), 32'(w));
    n = rd_q.size() - rb;
    for (int i = 0; i < w && i < n; i++)
      chk($sformatf("%s adr%0d", tag, i), rd_q[rb + i], {8'h00, v.exp_adr[i]});
    n = pop_q.size() - pb;
    for (int i = 0; i < w && i < n; i++) begin
      chk($sformatf("%s data%0d", tag, i), pop_q[pb + i][31:0], {8'h00, v.exp_adr[i]});
      chk($sformatf("%s last%0d", tag, i), 32'(pop_q[pb + i][32]), 32'(i == w - 1));
    end
    chk($sformatf("%s done_count", tag), 32'(done_cnt - db), 32'd1);
    if (w > 0) begin
      chk($sformatf("%s done_lat", tag), 32'(done_cyc - last_pop_cyc), 32'd1);
    end else begin
      chk($sformatf("%s no_cyc", tag), 32'(cyc_hi_cnt - cb), 32'd0);
      chk($sformatf("%s no_valid", tag), 32'(valid_cnt - vb), 32'd0);
      chk($sformatf("%s no_busy", tag), 32'(busy_cnt - bb), 32'd0);
    end
    $display("%s: addr=%06h words=%0d lat=%0d stall=%0d reads=%0d pops=%0d dones=%0d",
             tag, v.addr, w, v.lat, v.stall, rd_q.size() - rb, pop_q.size() - pb, done_cnt - db);
  endtask

  task automatic do_abort();
    int rb, db, t;
    bit got;
    rb = rd_q.size(); db = done_cnt;
    @(posedge clk); #1;
    lat = 3; out_ready = 1'b0;
    cmd_addr = 24'h300000; cmd_words = 16'd8; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    got = 1'b0; t = 0;
    // Abort in the cycle the third read is acknowledged (two words buffered).
    while (!got && t < 200) begin
      if (bus.m_wb_cyc_o && bus.m_wb_ack_i && (rd_q.size() - rb == 2)) got = 1'b1;
      else begin
        @(posedge clk); #1;
        t++;
      end
    end
    chk("abort reach", 32'(got), 32'd1);
    chk("abort pre_valid", 32'(out_valid), 32'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort cyc", 32'(bus.m_wb_cyc_o), 32'd0);
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (5) @(negedge clk);
    chk("abort no_done", 32'(done_cnt - db), 32'd0);
    chk("abort stays_idle", 32'(bus.m_wb_cyc_o), 32'd0);
    $display("abort: addr=300000 words=8 reads_before_abort=%0d dones=%0d", rd_q.size() - rb, done_cnt - db);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    vec_t pa;
    vecs[0] = '{addr: 24'h100000, words: 16'd4, stall: 0, lat: 0,
                exp_adr: {24'h100000, 24'h100004, 24'h100008, 24'h10000C,
                          24'h0, 24'h0, 24'h0, 24'h0}};
    vecs[1] = '{addr: 24'h200010, words: 16'd8, stall: 20, lat: 1,
                exp_adr: {24'h200010, 24'h200014, 24'h200018, 24'h20001C,
                          24'h200020, 24'h200024, 24'h200028, 24'h20002C}};
    vecs[2] = '{addr: 24'hFFFFF9, words: 16'd3, stall: 0, lat: 2,
                exp_adr: {24'hFFFFF8, 24'hFFFFFC, 24'h000000, 24'h0,
                          24'h0, 24'h0, 24'h0, 24'h0}};
    vecs[3] = '{addr: 24'h000123, words: 16'd0, stall: 0, lat: 0,
                exp_adr: {24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0}};
    vecs[4] = '{addr: 24'h00000E, words: 16'd1, stall: 0, lat: 1,
                exp_adr: {24'h00000C, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0}};
    tab[0] = 32'h0000_0001; tab[1] = 32'hFFFF_FFFF; tab[2] = 32'h0000_0010; tab[3] = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst cyc", 32'(bus.m_wb_cyc_o), 32'd0);
    chk("rst stb", 32'(bus.m_wb_stb_o), 32'd0);
    chk("rst adr", bus.m_wb_adr_o, 32'h0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_last", 32'(out_last), 32'd0);
    chk("rst out_data", out_data, 32'h0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    do_abort();
    pa = '{addr: 24'h000040, words: 16'd2, stall: 0, lat: 0,
           exp_adr: {24'h000040, 24'h000044, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0}};
    run_vec(pa, "post_abort");

`ifdef FLASH_STREAM_CHECKSUM_EN
    begin
      int db;
      db = done_cnt;
      tab_base = tab_idx;
      use_tab = 1'b1;
      @(posedge clk); #1;
      lat = 0; out_ready = 1'b1;
      cmd_addr = 24'h000400; cmd_words = 16'd3; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      wait_done(db, "checksum");
      repeat (2) @(negedge clk);
      chk("checksum at_done", ck_done, 32'h0000_0010);
      chk("checksum stable", checksum, 32'h0000_0010);
      $display("checksum: words=3 checksum=%08h", ck_done);
      use_tab = 1'b0;
    end
`endif

    chk("stb_equals_cyc", 32'(stb_err), 32'd0);
    chk("adr_stable", 32'(adr_err), 32'd0);
    chk("gap_after_ack", 32'(gap_err), 32'd0);
    chk("out_hold", 32'(hold_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
